// File: rtl/ahs_pkg.sv
// Shared types and helpers for the AHS vehicle control blocks.
package ahs_pkg;

  localparam int SERVICE_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAVEL = 2'd1,
    DWELL  = 2'd2,
    CLOSE  = 2'd3
  } state_t;

  // Bits needed to hold an index 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick enable every TICK_DIV clocks.
module tick_prescaler
  import ahs_pkg::*;
#(
  parameter int TICK_DIV = 65536
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int            DW   = idx_width(TICK_DIV);
  localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div_cnt;

  // Count 0..TICK_DIV-1 and wrap; nothing else ever restarts this counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/station_scheduler.sv
// Single-vehicle loop scheduler: latches stop requests, hops one station per
// travel period and dwells with doors open wherever a request is pending.
// Optional build macro SERVICE_COUNTER_EN adds a saturating dwell-entry counter;
// without it service_count reads zero.
module station_scheduler
  import ahs_pkg::*;
#(
  parameter int N_STATIONS   = 8,
  parameter int TICK_DIV     = 65536,
  parameter int TRAVEL_TICKS = 4,
  parameter int DWELL_TICKS  = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_STATIONS-1:0]         stop_req,
  input  logic                          hold,
  output logic                          tick,
  output logic [$clog2(N_STATIONS)-1:0] current_station,
  output logic                          moving,
  output logic                          doors_open,
  output logic [N_STATIONS-1:0]         pending,
  output logic [SERVICE_W-1:0]          service_count
);

  localparam int            SW    = idx_width(N_STATIONS);
  localparam int            TW    = idx_width(TRAVEL_TICKS);
  localparam int            DW    = idx_width(DWELL_TICKS);
  localparam logic [SW-1:0] SLAST = SW'(N_STATIONS - 1);
  localparam logic [TW-1:0] TLAST = TW'(TRAVEL_TICKS - 1);
  localparam logic [DW-1:0] DLAST = DW'(DWELL_TICKS - 1);

  state_t                  state, state_nx;
  logic [SW-1:0]           station_nx, next_station;
  logic [TW-1:0]           travel_cnt, travel_nx;
  logic [DW-1:0]           dwell_cnt, dwell_nx;
  logic [N_STATIONS-1:0]   pending_nx, clr;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  // Next-state logic; the current station's request is cleared while the doors are open.
  always_comb begin
    state_nx     = state;
    station_nx   = current_station;
    travel_nx    = travel_cnt;
    dwell_nx     = dwell_cnt;
    clr          = '0;
    next_station = (current_station == SLAST) ? '0 : current_station + 1'b1;
    case (state)
      IDLE: begin
        if (pending[current_station]) begin
          state_nx             = DWELL;
          dwell_nx             = '0;
          clr[current_station] = 1'b1;
        end else if (pending != '0) begin
          state_nx  = TRAVEL;
          travel_nx = '0;
        end
      end
      TRAVEL: begin
        if (tick) begin
          if (travel_cnt == TLAST) begin
            travel_nx  = '0;
            station_nx = next_station;
            if (pending[next_station] | stop_req[next_station]) begin
              state_nx = DWELL;
              dwell_nx = '0;
            end
          end else begin
            travel_nx = travel_cnt + 1'b1;
          end
        end
      end
      DWELL: begin
        clr[current_station] = 1'b1;
        if (tick) begin
          if (dwell_cnt == DLAST) begin
            if (!hold) begin
              state_nx = CLOSE;
            end
          end else begin
            dwell_nx = dwell_cnt + 1'b1;
          end
        end
      end
      CLOSE: begin
        if (tick) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    pending_nx = (pending | stop_req) & ~clr;
  end

  // State, position, timers and latched requests; reset aborts to a parked vehicle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      current_station <= '0;
      travel_cnt      <= '0;
      dwell_cnt       <= '0;
      pending         <= '0;
    end else begin
      state           <= state_nx;
      current_station <= station_nx;
      travel_cnt      <= travel_nx;
      dwell_cnt       <= dwell_nx;
      pending         <= pending_nx;
    end
  end

  assign moving     = (state == TRAVEL);
  assign doors_open = (state == DWELL);

`ifdef SERVICE_COUNTER_EN
  logic                 dwell_entry;
  logic [SERVICE_W-1:0] svc_cnt;

  assign dwell_entry = (state_nx == DWELL) && (state != DWELL);

  // Count arrivals into DWELL, holding at all-ones rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      svc_cnt <= '0;
    end else if (dwell_entry && (svc_cnt != '1)) begin
      svc_cnt <= svc_cnt + 1'b1;
    end
  end

  assign service_count = svc_cnt;
`else
  assign service_count = '0;
`endif

endmodule
